// File: rtl/dsd128_pkg.sv
// Shared constants, FSM encoding and lane-summing helper for the DSD128 FIR sequencer.
package dsd128_pkg;
    localparam int N_TAPS     = 320;
    localparam int N_LANES    = 10;
    localparam int N_ADDR     = 32;
    localparam int TAP_W      = 32;
    localparam int LANE_SUM_W = 36;

    // Idle DSD pattern: +1 at even indices, -1 at odd indices.
    localparam logic [N_TAPS-1:0] DSD_SILENCE = {(N_TAPS/2){2'b01}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic logic signed [LANE_SUM_W-1:0] sum_lanes(
        input logic [N_LANES*TAP_W-1:0] taps
    );
        logic signed [LANE_SUM_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_LANES; i++) begin
            s = s + $signed({{(LANE_SUM_W-TAP_W){taps[TAP_W*i+TAP_W-1]}},
                             taps[TAP_W*i +: TAP_W]});
        end
        return s;
    endfunction
endpackage

// File: rtl/dsd128_lane_sum.sv
// Ten-lane signed tap adder, widened to the accumulator width.
module dsd128_lane_sum
    import dsd128_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [N_LANES*TAP_W-1:0] taps,
    output logic signed [ACC_W-1:0]  sum
);
    logic signed [LANE_SUM_W-1:0] raw;

    assign raw = sum_lanes(taps);
    assign sum = ACC_W'(raw);
endmodule

// File: rtl/dsd128_fir_ctrl.sv
// DSD128 stereo decimator sequencer: keeps bit histories, walks the tap ROM
// once per output sample and emits a saturated PCM pair.
module dsd128_fir_ctrl
    import dsd128_pkg::*;
#(
    parameter int DECIM     = 32,
    parameter int ACC_W     = 40,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dsd_valid,
    input  logic                    dsd_l,
    input  logic                    dsd_r,
    output logic [4:0]              rom_addr,
    output logic [9:0]              rom_x,
    output logic [9:0]              rom_y,
    input  logic [319:0]            rom_tap_l,
    input  logic [319:0]            rom_tap_r,
    output logic                    pcm_valid,
    output logic signed [OUT_W-1:0] pcm_l,
    output logic signed [OUT_W-1:0] pcm_r,
    output logic                    busy,
    output logic                    overrun
);
    localparam int PH_W  = 8;
    localparam int CNT_W = 6;
    localparam logic signed [ACC_W-1:0] PCM_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] PCM_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    state_t                  state_reg, state_next;
    logic [PH_W-1:0]         phase_reg;
    logic [CNT_W-1:0]        cnt_reg;
    logic [N_TAPS-1:0]       hist_l_reg, hist_r_reg, snap_l_reg, snap_r_reg;
    logic [N_TAPS-1:0]       hist_l_next, hist_r_next;
    logic signed [ACC_W-1:0] stage_l_reg, stage_r_reg, acc_l_reg, acc_r_reg;
    logic signed [ACC_W-1:0] lane_l, lane_r;
    logic                    trigger, accept, run_done;

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] t;
        t = acc >>> OUT_SHIFT;
        if (t > PCM_MAX)      t = PCM_MAX;
        else if (t < PCM_MIN) t = PCM_MIN;
        return t[OUT_W-1:0];
    endfunction

    dsd128_lane_sum #(.ACC_W(ACC_W)) u_sum_l (.taps(rom_tap_l), .sum(lane_l));
    dsd128_lane_sum #(.ACC_W(ACC_W)) u_sum_r (.taps(rom_tap_r), .sum(lane_r));

    assign hist_l_next = {hist_l_reg[N_TAPS-2:0], dsd_l};
    assign hist_r_next = {hist_r_reg[N_TAPS-2:0], dsd_r};
    assign trigger     = dsd_valid && (phase_reg == PH_W'(DECIM - 1));
    // A trigger landing on the DRAIN cycle is accepted: the ROM walk is already finished.
    assign accept      = trigger && (state_reg != ST_RUN);
    assign run_done    = (state_reg == ST_RUN) && (cnt_reg == CNT_W'(N_ADDR));
    assign busy        = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (accept) state_next = ST_RUN;
            ST_RUN:   if (run_done) state_next = ST_DRAIN;
            ST_DRAIN: state_next = accept ? ST_RUN : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg   <= '0;
            cnt_reg     <= '0;
            hist_l_reg  <= DSD_SILENCE;
            hist_r_reg  <= DSD_SILENCE;
            snap_l_reg  <= '0;
            snap_r_reg  <= '0;
            stage_l_reg <= '0;
            stage_r_reg <= '0;
            acc_l_reg   <= '0;
            acc_r_reg   <= '0;
            rom_addr    <= '0;
            rom_x       <= '0;
            rom_y       <= '0;
            pcm_valid   <= 1'b0;
            pcm_l       <= '0;
            pcm_r       <= '0;
            overrun     <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (dsd_valid) begin
                hist_l_reg <= hist_l_next;
                hist_r_reg <= hist_r_next;
                phase_reg  <= trigger ? '0 : phase_reg + 1'b1;
            end
            if (trigger && (state_reg == ST_RUN)) overrun <= 1'b1;

            if (accept) begin
                // Address 0 goes out now; the snapshot keeps the rest, consumed 10 bits per step.
                rom_addr   <= '0;
                rom_x      <= hist_l_next[N_LANES-1:0];
                rom_y      <= hist_r_next[N_LANES-1:0];
                snap_l_reg <= hist_l_next >> N_LANES;
                snap_r_reg <= hist_r_next >> N_LANES;
                cnt_reg    <= '0;
            end else if (state_reg == ST_RUN) begin
                cnt_reg     <= cnt_reg + 1'b1;
                stage_l_reg <= lane_l;
                stage_r_reg <= lane_r;
                if (cnt_reg == '0) begin
                    acc_l_reg <= '0;
                    acc_r_reg <= '0;
                end else begin
                    acc_l_reg <= acc_l_reg + stage_l_reg;
                    acc_r_reg <= acc_r_reg + stage_r_reg;
                end
                if (cnt_reg < CNT_W'(N_ADDR - 1)) begin
                    rom_addr   <= rom_addr + 1'b1;
                    rom_x      <= snap_l_reg[N_LANES-1:0];
                    rom_y      <= snap_r_reg[N_LANES-1:0];
                    snap_l_reg <= snap_l_reg >> N_LANES;
                    snap_r_reg <= snap_r_reg >> N_LANES;
                end else begin
                    rom_addr <= '0;
                    rom_x    <= '0;
                    rom_y    <= '0;
                end
            end

            if (state_reg == ST_DRAIN) begin
                pcm_l     <= saturate(acc_l_reg);
                pcm_r     <= saturate(acc_r_reg);
                pcm_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dsd128_fir_ctrl.sv
// Randomized scoreboard bench for dsd128_fir_ctrl with a behavioural FIR model and ROM.
module tb_dsd128_fir_ctrl;
    localparam int DECIM     = 32;
    localparam int OUT_W     = 24;
    localparam int OUT_SHIFT = 8;
    localparam int LAT       = 34;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               dsd_valid = 1'b0, dsd_l = 1'b0, dsd_r = 1'b0;
    logic [4:0]         rom_addr;
    logic [9:0]         rom_x, rom_y;
    logic [319:0]       rom_tap_l, rom_tap_r;
    logic               pcm_valid, busy, overrun;
    logic signed [23:0] pcm_l, pcm_r;

    always #5 clk = ~clk;

    dsd128_fir_ctrl #(.DECIM(DECIM), .ACC_W(40), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)) dut (
        .clk(clk), .rst_n(rst_n), .dsd_valid(dsd_valid), .dsd_l(dsd_l), .dsd_r(dsd_r),
        .rom_addr(rom_addr), .rom_x(rom_x), .rom_y(rom_y),
        .rom_tap_l(rom_tap_l), .rom_tap_r(rom_tap_r),
        .pcm_valid(pcm_valid), .pcm_l(pcm_l), .pcm_r(pcm_r),
        .busy(busy), .overrun(overrun)
    );

    // Coefficient ROM: lane i at address a returns +/- coef[10a+i] depending on its sign bit.
    int coef [320];
    always_comb begin
        rom_tap_l = '0;
        rom_tap_r = '0;
        for (int i = 0; i < 10; i++) begin
            rom_tap_l[32*i +: 32] = rom_x[i] ? coef[10*rom_addr+i] : -coef[10*rom_addr+i];
            rom_tap_r[32*i +: 32] = rom_y[i] ? coef[10*rom_addr+i] : -coef[10*rom_addr+i];
        end
    end

    typedef struct { longint l; longint r; int c; } exp_t;
    exp_t q[$];
    bit   hl [320], hr [320], sl [320], sr [320];
    int   phase, last_t, cyc, total, bad, samples;
    bit   ovr_exp;

    function automatic void chk(string name, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic longint ref_pcm(longint acc);
        longint t, hi, lo;
        t  = acc >>> OUT_SHIFT;
        hi = (longint'(1) <<< (OUT_W-1)) - 1;
        lo = -(longint'(1) <<< (OUT_W-1));
        if (t > hi) t = hi;
        if (t < lo) t = lo;
        return t;
    endfunction

    function automatic void model_reset();
        for (int n = 0; n < 320; n++) begin
            hl[n] = (n % 2 == 0);
            hr[n] = (n % 2 == 0);
        end
        phase   = 0;
        last_t  = -1000;
        ovr_exp = 1'b0;
        q.delete();
    endfunction

    // One accepted bit pair: FIR output is sum over n of (+1/-1 by history bit n) * coef[n].
    function automatic void model_pair(bit l, bit r);
        exp_t   e;
        longint al, ar;
        for (int n = 319; n > 0; n--) begin
            hl[n] = hl[n-1];
            hr[n] = hr[n-1];
        end
        hl[0] = l;
        hr[0] = r;
        if (phase == DECIM - 1) begin
            if (cyc - last_t < LAT) begin
                ovr_exp = 1'b1;
            end else begin
                last_t = cyc;
                al = 0;
                ar = 0;
                for (int n = 0; n < 320; n++) begin
                    sl[n] = hl[n];
                    sr[n] = hr[n];
                    al += hl[n] ? longint'(coef[n]) : -longint'(coef[n]);
                    ar += hr[n] ? longint'(coef[n]) : -longint'(coef[n]);
                end
                e.l = ref_pcm(al);
                e.r = ref_pcm(ar);
                e.c = cyc + LAT;
                q.push_back(e);
            end
            phase = 0;
        end else begin
            phase++;
        end
    endfunction

    task automatic tick(bit v, bit l, bit r);
        dsd_valid = v;
        dsd_l     = l;
        dsd_r     = r;
        @(posedge clk);
        cyc++;
        if (rst_n && v) model_pair(l, r);
        #1;
    endtask

    task automatic pairs(int n, int gap, int mode);
        for (int k = 0; k < n; k++) begin
            if (mode == 1) tick(1'b1, 1'b1, 1'b0);
            else           tick(1'b1, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((busy || q.size() != 0) && n < 200) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        chk("drain_timeout", n < 200, 1);
    endtask

    task automatic load_coef(int lo, int hi, bit centred);
        for (int n = 0; n < 320; n++)
            coef[n] = centred ? int'($urandom_range(2*hi, 0)) - hi : int'($urandom_range(hi, lo));
    endtask

    // Monitor: every cycle compares the DUT against what the model says should be visible.
    initial begin : monitor
        longint hold_l, hold_r;
        int     d, ea;
        logic [9:0] ex, ey;
        bit     exp_valid;
        exp_t   e;
        hold_l = 0;
        hold_r = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_l = 0;
                hold_r = 0;
            end
            d  = cyc - last_t;
            ea = (d >= 0 && d <= 31) ? d : -1;
            ex = '0;
            ey = '0;
            if (ea >= 0)
                for (int j = 0; j < 10; j++) begin
                    ex[j] = sl[10*ea+j];
                    ey[j] = sr[10*ea+j];
                end
            chk("busy", busy, (d >= 0 && d <= 33));
            chk("rom_addr", rom_addr, (ea >= 0) ? ea : 0);
            chk("rom_x", rom_x, ex);
            chk("rom_y", rom_y, ey);
            chk("overrun", overrun, ovr_exp);
            exp_valid = (q.size() != 0) && (q[0].c == cyc);
            chk("pcm_valid", pcm_valid, exp_valid);
            if (q.size() != 0 && (pcm_valid || q[0].c < cyc)) begin
                e = q.pop_front();
                hold_l = e.l;
                hold_r = e.r;
                samples++;
                $display("sample %0d cycle %0d pcm_l=%0d pcm_r=%0d (model %0d %0d)",
                         samples, cyc, pcm_l, pcm_r, e.l, e.r);
            end
            chk("pcm_l", pcm_l, hold_l);
            chk("pcm_r", pcm_r, hold_r);
        end
    end

    initial begin : stimulus
        bit alt;
        int n;
        total = 0; bad = 0; cyc = 0; samples = 0;
        load_coef(0, 1 << 20, 1'b1);
        model_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);

        // Constant +1 left / -1 right for a full history, half duty.
        pairs(320, 1, 1);
        drain();

        // Sparse random input, one pair every fourth cycle.
        pairs(10 * DECIM, 3, 0);
        drain();

        // Silence history aligned to a trigger boundary, then one flipped left bit landing at index 137.
        alt = 1'b0;
        for (int k = 0; k < 330 || phase != 0; k++) begin
            alt = ~alt;
            tick(1'b1, alt, alt);
            tick(1'b0, 1'b0, 1'b0);
        end
        for (int m = 1; m <= 192; m++) begin
            alt = ~alt;
            tick(1'b1, (m == 160 - 137) ? ~alt : alt, alt);
            tick(1'b0, 1'b0, 1'b0);
        end
        drain();

        // Back-to-back input: second trigger lands while the ROM walk is still running.
        pairs(100, 0, 0);
        drain();

        // Large positive coefficients drive both channels into saturation.
        load_coef(1 << 28, (1 << 29) - 1, 1'b0);
        pairs(352, 1, 1);
        drain();
        load_coef(0, 1 << 20, 1'b1);

        // Reset in the middle of a ROM walk.
        n = 0;
        while (!(busy && rom_addr == 5'd17) && n < 2000) begin
            pairs(1, 1, 0);
            n++;
        end
        chk("reach_addr17", n < 2000, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rom_addr", rom_addr, 0);
        chk("async_rom_x", rom_x, 0);
        chk("async_busy", busy, 0);
        chk("async_pcm_l", pcm_l, 0);
        chk("async_overrun", overrun, 0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        pairs(96, 1, 0);
        drain();

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
